// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a five-stage ARM pipeline (F/D/E/M/W).
//   * E-stage operand forwarding selects (M result over W result).
//   * Load-use stall: hold F and D, bubble into E for one cycle.
//   * PC-write handling: the decoder reports a PC-writing instruction only
//     while it sits in D; a three-bit shadow pipeline follows it through
//     E, M and W so fetch stays stalled and D stays flushed until the new
//     PC is written back.
//   * Branch-taken redirect: flush D and E in the resolving cycle.
//   * Two saturating performance counters (stall cycles, redirect events).
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   RA1D, RA2D                source registers of the instruction in D
//   RA1E, RA2E                source registers of the instruction in E
//   WA3E, WA3M, WA3W          destination registers in E, M, W
//   RegWriteM, RegWriteW      register-write enables in M, W
//   MemtoRegE                 instruction in E is a load
//   PCSrcD                    valid instruction in D writes R15
//   BranchTakenE              branch resolved taken in E this cycle
//   perf_clr                  synchronous clear of both counters
//   ForwardAE, ForwardBE      00 register file, 01 W result, 10 M result
//   StallF, StallD            hold PC register / hold F->D register
//   FlushD, FlushE            bubble into F->D register / D->E register
//   stall_cnt                 cycles with StallF high (saturating)
//   flush_cnt                 redirect events (saturating)
//
// All stall/flush/forward outputs are combinational from the inputs and the
// shadow bits; the counters are registered.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             perf_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow pipeline: marks a PC-writing instruction in E, M and W.
    logic r_pcw_e;
    logic r_pcw_m;
    logic r_pcw_w;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_ldrstall;
    logic       w_pcw_pend;
    logic       w_stall_f;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_redirect;

    // ------------------------------------------------------------------------
    // Forwarding. R15 is never forwarded: reads of the PC come from the PC
    // path, not from an in-flight ALU result.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd_a = 2'b00;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != 4'hF)) begin
            w_fwd_a = 2'b10;
        end else if (RegWriteW && (WA3W == RA1E) && (RA1E != 4'hF)) begin
            w_fwd_a = 2'b01;
        end
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != 4'hF)) begin
            w_fwd_b = 2'b10;
        end else if (RegWriteW && (WA3W == RA2E) && (RA2E != 4'hF)) begin
            w_fwd_b = 2'b01;
        end
    end

    // ------------------------------------------------------------------------
    // Stall / flush generation.
    // A load in E cannot forward to D's consumer this cycle; holding one cycle
    // lets the load reach M after which W-forwarding covers the dependency.
    // ------------------------------------------------------------------------
    assign w_ldrstall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));

    // A PC write is pending while the instruction is in D, E or M; fetch must
    // not advance until the new PC lands in W.
    assign w_pcw_pend = PCSrcD | r_pcw_e | r_pcw_m;

    assign w_stall_f  = w_ldrstall | w_pcw_pend;
    assign w_flush_e  = w_ldrstall | BranchTakenE;
    // D keeps being flushed through the W cycle, since whatever was fetched
    // before the PC write completed is on the wrong path.
    assign w_flush_d  = w_pcw_pend | r_pcw_w | BranchTakenE;

    assign w_redirect = BranchTakenE | r_pcw_w;

    // ------------------------------------------------------------------------
    // Shadow pipeline. If the PC-writing instruction is held in D by a
    // load-use stall, FlushE turns its E slot into a bubble, so the shadow
    // bit must not start until the instruction really enters E.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcw_e <= 1'b0;
            r_pcw_m <= 1'b0;
            r_pcw_w <= 1'b0;
        end else begin
            r_pcw_e <= PCSrcD & ~w_flush_e;
            r_pcw_m <= r_pcw_e;
            r_pcw_w <= r_pcw_m;
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters. Clear wins over everything; a stall cycle is
    // counted in preference to a redirect in the same cycle. Both saturate.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_stall_f) begin
            if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else if (w_redirect) begin
            if (r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;
    assign StallF    = w_stall_f;
    assign StallD    = w_ldrstall;
    assign FlushD    = w_flush_d;
    assign FlushE    = w_flush_e;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed sequences followed by random traffic. Each cycle the bench computes
// the expected outputs from its own model of the hazard rules, pushes them to
// exp_q, and pops/compares them half a cycle later. Directed sequences also
// check sampled outputs against fixed constants.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE, perf_clr;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .perf_clr     (perf_clr),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             sf;
        logic             sd;
        logic             fd;
        logic             fe;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic             m_pcw_e, m_pcw_m, m_pcw_w;
    logic [CNT_W-1:0] m_sc, m_fc;

    // last sampled DUT outputs, for directed constant checks
    logic             s_sf, s_sd, s_fd, s_fe;
    logic [1:0]       s_fa, s_fb;
    logic [CNT_W-1:0] s_sc, s_fc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [3:0] r);
        if (RegWriteM && WA3M == r && r != 4'hF) return 2'b10;
        if (RegWriteW && WA3W == r && r != 4'hF) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic ldr, pend;
        ldr  = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        pend = PCSrcD || m_pcw_e || m_pcw_m;
        e.fa = fwd_sel(RA1E);
        e.fb = fwd_sel(RA2E);
        e.sf = ldr || pend;
        e.sd = ldr;
        e.fe = ldr || BranchTakenE;
        e.fd = pend || m_pcw_w || BranchTakenE;
        e.sc = m_sc;
        e.fc = m_fc;
        return e;
    endfunction

    task automatic model_clock(input exp_t e);
        logic old_w;
        old_w   = m_pcw_w;
        m_pcw_w = m_pcw_m;
        m_pcw_m = m_pcw_e;
        m_pcw_e = PCSrcD && !e.fe;
        if (perf_clr) begin
            m_sc = '0;
            m_fc = '0;
        end else if (e.sf) begin
            if (m_sc != {CNT_W{1'b1}}) m_sc = m_sc + 1'b1;
        end else if (BranchTakenE || old_w) begin
            if (m_fc != {CNT_W{1'b1}}) m_fc = m_fc + 1'b1;
        end
    endtask

    task automatic model_reset();
        m_pcw_e = 1'b0;
        m_pcw_m = 1'b0;
        m_pcw_w = 1'b0;
        m_sc    = '0;
        m_fc    = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic zero_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
        WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; BranchTakenE = 0; perf_clr = 0;
    endtask

    // Called at posedge+1 with inputs already set: queue expectation, compare
    // at negedge, then advance the model across the next posedge.
    task automatic step();
        exp_t e;
        exp_q.push_back(model_out());
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("ForwardAE", 32'(ForwardAE), 32'(e.fa));
        check_val("ForwardBE", 32'(ForwardBE), 32'(e.fb));
        check_val("StallF",    32'(StallF),    32'(e.sf));
        check_val("StallD",    32'(StallD),    32'(e.sd));
        check_val("FlushD",    32'(FlushD),    32'(e.fd));
        check_val("FlushE",    32'(FlushE),    32'(e.fe));
        check_val("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        check_val("flush_cnt", 32'(flush_cnt), 32'(e.fc));
        s_fa = ForwardAE; s_fb = ForwardBE;
        s_sf = StallF; s_sd = StallD; s_fd = FlushD; s_fe = FlushE;
        s_sc = stall_cnt; s_fc = flush_cnt;
        @(posedge clk);
        model_clock(e);
        #1;
    endtask

    task automatic idle_step();
        zero_inputs();
        step();
    endtask

    task automatic clear_counters();
        zero_inputs();
        perf_clr = 1;
        step();
        perf_clr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctrl"}, 32'({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}), 32'd0);
        check_val({tag, "_cnt"},  32'({stall_cnt, flush_cnt}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] exp_sf5;
        logic [4:0] exp_fd5;
        logic [5:0] exp_fd6;

        zero_inputs();
        model_reset();
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_during");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_after");

        // Forwarding: ADD R1 -> SUB R2,R1
        zero_inputs();
        RegWriteM = 1; WA3M = 1; RA1E = 1; RA2E = 1;
        step();
        check_val("fwd_m_only", 32'(s_fa), 32'd2);
        check_val("fwdB_m_only", 32'(s_fb), 32'd2);
        RegWriteW = 1; WA3W = 1;
        step();
        check_val("fwd_m_over_w", 32'(s_fa), 32'd2);
        RegWriteM = 0;
        step();
        check_val("fwd_w_only", 32'(s_fa), 32'd1);
        RegWriteM = 1; WA3M = 15; WA3W = 15; RA1E = 15; RA2E = 2;
        step();
        check_val("fwd_r15", 32'(s_fa), 32'd0);
        check_val("fwdB_none", 32'(s_fb), 32'd0);

        // Load-use: LDR R3 in E, RA2D=3
        clear_counters();
        zero_inputs();
        MemtoRegE = 1; WA3E = 3; RA2D = 3;
        step();
        check_val("ldr_stallF", 32'(s_sf), 32'd1);
        check_val("ldr_stallD", 32'(s_sd), 32'd1);
        check_val("ldr_flushE", 32'(s_fe), 32'd1);
        idle_step();
        check_val("ldr_release", 32'({s_sf, s_sd, s_fe}), 32'd0);
        check_val("ldr_stall_cnt", 32'(s_sc), 32'd1);

        // PCSrcD one-cycle pulse
        clear_counters();
        exp_sf5 = 5'b00111;   // bit i = cycle i
        exp_fd5 = 5'b01111;
        zero_inputs();
        PCSrcD = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            PCSrcD = 0;
            check_val($sformatf("pcw_stallF_%0d", i), 32'(s_sf), 32'(exp_sf5[i]));
            check_val($sformatf("pcw_flushD_%0d", i), 32'(s_fd), 32'(exp_fd5[i]));
        end
        check_val("pcw_flush_cnt", 32'(s_fc), 32'd1);

        // PCSrcD held two cycles, load-use in the first
        clear_counters();
        exp_sf5 = 5'b01111;
        exp_fd6 = 6'b011111;
        zero_inputs();
        PCSrcD = 1; MemtoRegE = 1; WA3E = 3; RA1D = 3;
        step();
        check_val("pcw_ldr_stallF_0", 32'(s_sf), 32'd1);
        check_val("pcw_ldr_flushD_0", 32'(s_fd), 32'd1);
        zero_inputs();
        PCSrcD = 1;
        for (int i = 1; i < 6; i++) begin
            step();
            PCSrcD = 0;
            if (i < 5) check_val($sformatf("pcw_ldr_stallF_%0d", i), 32'(s_sf), 32'(exp_sf5[i]));
            check_val($sformatf("pcw_ldr_flushD_%0d", i), 32'(s_fd), 32'(exp_fd6[i]));
        end

        // Branch taken for one cycle
        clear_counters();
        zero_inputs();
        BranchTakenE = 1;
        step();
        check_val("br_flushD", 32'(s_fd), 32'd1);
        check_val("br_flushE", 32'(s_fe), 32'd1);
        check_val("br_stallF", 32'(s_sf), 32'd0);
        idle_step();
        check_val("br_flush_cnt", 32'(s_fc), 32'd1);

        // Asynchronous reset while the PC write sits in M
        zero_inputs();
        PCSrcD = 1;
        step();          // D
        idle_step();     // E
        check_val("mid_pending", 32'(StallF), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle_step();
        check_val("post_reset_stallF", 32'(s_sf), 32'd0);

        // Saturation of the 2-bit stall counter, then clear
        clear_counters();
        zero_inputs();
        MemtoRegE = 1; WA3E = 3; RA1D = 3;
        repeat (5) step();
        idle_step();
        check_val("stall_saturated", 32'(s_sc), 32'd3);
        clear_counters();
        idle_step();
        check_val("stall_cleared", 32'(s_sc), 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] regs[7];
            for (int k = 0; k < 7; k++) begin
                regs[k] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            end
            RA1D = regs[0]; RA2D = regs[1]; RA1E = regs[2]; RA2E = regs[3];
            WA3E = regs[4]; WA3M = regs[5]; WA3W = regs[6];
            RegWriteM    = ($urandom_range(0, 1) == 1);
            RegWriteW    = ($urandom_range(0, 1) == 1);
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            PCSrcD       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            perf_clr     = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller for the five-stage ARM pipeline (F/D/E/M/W). It generates the E-stage forwarding selects, load-use stalls, and branch/PC-write flushes. It also tracks in-flight PC-writing instructions in an internal shadow pipeline, so the decoder only has to report them once, in D. Two saturating event counters expose stall and redirect activity for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- RA1D, RA2D  in  4  source register addresses of the instruction in D
- RA1E, RA2E  in  4  source register addresses of the instruction in E
- WA3E, WA3M, WA3W  in  4  destination register addresses in E, M and W
- RegWriteM, RegWriteW  in  1  register-write enables in M and W
- MemtoRegE  in  1  the instruction in E is a load (LDR)
- PCSrcD  in  1  the valid instruction in D writes R15 (decoder output)
- BranchTakenE  in  1  branch resolved taken in E this cycle
- perf_clr  in  1  synchronous clear of both counters
- ForwardAE, ForwardBE  out  2  E-stage operand select: 00 register file, 01 W result, 10 M ALU result
- StallF, StallD  out  1  hold the PC register / hold the F→D register
- FlushD, FlushE  out  1  insert a bubble into the F→D register / the D→E register
- stall_cnt  out  CNT_W  number of cycles with StallF high
- flush_cnt  out  CNT_W  number of redirect events

## Operation
- Forwarding (per operand X ∈ {A,B}, source RXE):
  - 10 if RegWriteM, WA3M==RXE and RXE!=4'hF.
  - Otherwise 01 if RegWriteW, WA3W==RXE and RXE!=4'hF.
  - Otherwise 00.
  - A match in M has priority over a match in W.
- Load-use: ldrstall = MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
- PC-write shadow pipeline: three registered bits pcw_E, pcw_M, pcw_W, updated every clock edge:
  - pcw_E <= PCSrcD & ~FlushE
  - pcw_M <= pcw_E
  - pcw_W <= pcw_M
- pcw_pend = PCSrcD | pcw_E | pcw_M.
- Control outputs (all combinational from inputs and the shadow bits):
  - StallF = ldrstall | pcw_pend
  - StallD = ldrstall
  - FlushE = ldrstall | BranchTakenE
  - FlushD = pcw_pend | pcw_W | BranchTakenE
- Simultaneous events:
  - StallD and FlushD may both be high. The D-register owner applies flush over stall.
  - When BranchTakenE and ldrstall are both high, FlushE is a single bubble and StallF=1.
- Counters, in priority order:
  - perf_clr=1: both counters go to 0, and no increment happens that cycle.
  - Otherwise stall_cnt increments when StallF=1.
  - Otherwise flush_cnt increments when BranchTakenE | pcw_W.
  - Both counters saturate at all-ones (no wrap).

## Timing
- Reset (reset_n=0, asynchronous): pcw_E/M/W = 0, stall_cnt = flush_cnt = 0.
  - With all inputs at 0, every output is 0 during and after reset.
  - A reset mid-flight discards any pending PC write: fetch resumes immediately after reset release.
- Forwarding and all stall/flush outputs are zero-latency (same cycle as their inputs).
- A load-use stall lasts exactly one cycle: the load then moves to M, and the dependent instruction is served by forwarding.
- A PC-writing instruction sitting in D for one cycle (no stall) gives:
  - StallF high for 3 cycles (instruction in D, E, M).
  - FlushD high for 4 cycles (instruction in D, E, M, W).
  - flush_cnt +1 in the W cycle.
- If that instruction is held in D by ldrstall, pcw_E stays 0 because FlushE blocks it. The pipeline then starts one cycle later.
- Counter values are registered: they update on the clock edge after the event.

## Test plan
- Back-to-back ADD R1 → SUB R2,R1 (WA3M=1, RegWriteM=1, RA1E=1) → ForwardAE=10. Adding WA3W=1, RegWriteW=1 keeps ForwardAE=10. With only the W match → 01. RA1E=15 with matches → 00.
- LDR R3 in E (MemtoRegE=1, WA3E=3), RA2D=3 → StallF=StallD=FlushE=1 for exactly 1 cycle, then 0. stall_cnt=1 on the next edge.
- PCSrcD pulse of 1 cycle → StallF 1,1,1,0; FlushD 1,1,1,1,0 over the following cycles. flush_cnt=1 after the W cycle.
- PCSrcD held 2 cycles together with ldrstall in the first cycle → pcw_E stays 0 on the first edge. StallF stays high 4 cycles total.
- BranchTakenE for 1 cycle → FlushD=FlushE=1 that cycle, StallF=0. flush_cnt +1.
- Assert reset_n=0 asynchronously while pcw_M=1 → all outputs are 0 immediately. With CNT_W=2, 5 stall cycles → stall_cnt=3 (saturated). perf_clr → 0 on the next edge.
